// File: rtl/nx_transmitter.sv
// Serialises one message (target, command, masked payload beats) onto a
// valid/ready command bus, one BUS_W beat per handshake.
module nx_transmitter #(
  parameter int TARGET_W  = 8,
  parameter int BUS_W     = 8,
  parameter int PAYLOAD_W = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [TARGET_W-1:0]            tx_target,
  input  logic [BUS_W-1:0]               tx_command,
  input  logic [PAYLOAD_W-1:0]           tx_payload,
  input  logic [PAYLOAD_W/BUS_W-1:0]     tx_valid,
  input  logic                           tx_start,
  output logic                           tx_ready,
  output logic [BUS_W-1:0]               cmd_data,
  output logic                           cmd_last,
  output logic                           cmd_valid,
  input  logic                           cmd_ready
);

  localparam int N  = PAYLOAD_W / BUS_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_TARGET, S_COMMAND, S_PAYLOAD} state_t;

  state_t                r_state, w_next;
  logic [TARGET_W-1:0]   r_target;
  logic [BUS_W-1:0]      r_command;
  logic [PAYLOAD_W-1:0]  r_payload;
  logic [N-1:0]          r_mask;
  logic [IW-1:0]         w_hi;
  logic                  w_mask_one;
  logic                  w_accept;
  logic                  w_done;

  // Highest set mask bit picks the payload beat; ascending scan keeps the last hit.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++)
      if (r_mask[i]) w_hi = IW'(i);
  end

  assign w_mask_one = ((r_mask & (r_mask - ONE)) == '0);

  always_comb begin
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    cmd_data  = '0;
    w_next    = r_state;
    case (r_state)
      S_TARGET: begin
        cmd_valid = 1'b1;
        cmd_data  = BUS_W'(r_target);
      end
      S_COMMAND: begin
        cmd_valid = 1'b1;
        cmd_data  = r_command;
        cmd_last  = (r_mask == '0);
      end
      S_PAYLOAD: begin
        cmd_valid = 1'b1;
        cmd_data  = r_payload[w_hi*BUS_W +: BUS_W];
        cmd_last  = w_mask_one;
      end
      default: ;
    endcase

    w_done   = cmd_valid && cmd_ready && cmd_last;
    // Gated by rst so the block never advertises readiness while held in reset.
    tx_ready = rst && ((r_state == S_IDLE) || w_done);
    w_accept = tx_start && tx_ready;

    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_TARGET;
      S_TARGET:  if (cmd_ready) w_next = S_COMMAND;
      S_COMMAND: if (cmd_ready) w_next = (r_mask != '0) ? S_PAYLOAD
                                        : (w_accept ? S_TARGET : S_IDLE);
      S_PAYLOAD: if (w_done) w_next = w_accept ? S_TARGET : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_target  <= '0;
      r_command <= '0;
      r_payload <= '0;
      r_mask    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_target  <= tx_target;
        r_command <= tx_command;
        r_payload <= tx_payload;
        r_mask    <= tx_valid;
      end else if (r_state == S_PAYLOAD && cmd_ready) begin
        r_mask[w_hi] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nx_transmitter.sv
// Directed vector table plus multi-cycle sequences and a randomised
// stall stream checked against a queue of expected beats.
module tb_nx_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_target, tx_command;
  logic [23:0] tx_payload;
  logic [2:0]  tx_valid;
  logic        tx_start, tx_ready;
  logic [7:0]  cmd_data;
  logic        cmd_last, cmd_valid, cmd_ready;

  int n_chk = 0;
  int n_pass = 0;

  nx_transmitter #(.TARGET_W(8), .BUS_W(8), .PAYLOAD_W(24)) dut (
    .clk(clk), .rst(rst),
    .tx_target(tx_target), .tx_command(tx_command), .tx_payload(tx_payload),
    .tx_valid(tx_valid), .tx_start(tx_start), .tx_ready(tx_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  c;
    logic [23:0] p;
    logic [2:0]  v;
    int          n;
    logic [39:0] beats;  // first beat in [39:32]
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] t, input logic [7:0] c,
                      input logic [23:0] p, input logic [2:0] v);
    int k = 0;
    while (!tx_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk("ready_before_send", {31'd0, tx_ready}, 1);
    tx_target = t; tx_command = c; tx_payload = p; tx_valid = v; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    // Scribble inputs: the message in flight must come from the captured copy.
    tx_target = 8'hEE; tx_command = 8'hEE; tx_payload = 24'hEEEEEE; tx_valid = 3'b010;
  endtask

  task automatic expect_beats(input vec_t e);
    for (int j = 0; j < e.n; j++) begin
      chk("beat_valid", {31'd0, cmd_valid}, 1);
      chk("beat_data", {24'd0, cmd_data}, {24'd0, e.beats[(4-j)*8 +: 8]});
      chk("beat_last", {31'd0, cmd_last}, (j == e.n-1) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("idle_valid", {31'd0, cmd_valid}, 0);
    chk("idle_ready", {31'd0, tx_ready}, 1);
  endtask

  logic [8:0] q[$];
  bit prod_done = 1'b0;

  initial begin
    logic [7:0] b2b[6];
    tbl[0] = '{8'h12, 8'h34, 24'hAABBCC, 3'b111, 5, 40'h12_34_AA_BB_CC};
    tbl[1] = '{8'h01, 8'h80, 24'h112233, 3'b101, 4, 40'h01_80_11_33_00};
    tbl[2] = '{8'h05, 8'h06, 24'h999999, 3'b000, 2, 40'h05_06_00_00_00};
    tbl[3] = '{8'hFF, 8'h00, 24'h123456, 3'b010, 3, 40'hFF_00_34_00_00};
    tbl[4] = '{8'h7E, 8'h55, 24'hDEADBE, 3'b100, 3, 40'h7E_55_DE_00_00};

    rst = 1'b0; tx_start = 1'b0; cmd_ready = 1'b1;
    tx_target = '0; tx_command = '0; tx_payload = '0; tx_valid = '0;
    #3;
    chk("rst_valid", {31'd0, cmd_valid}, 0);
    chk("rst_ready", {31'd0, tx_ready}, 0);
    chk("rst_data",  {24'd0, cmd_data}, 0);
    chk("rst_last",  {31'd0, cmd_last}, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("post_rst_ready", {31'd0, tx_ready}, 1);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].t, tbl[i].c, tbl[i].p, tbl[i].v);
      expect_beats(tbl[i]);
    end

    // Back-to-back: second message held on tx_start while the first drains.
    b2b = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    tx_target = 8'hA1; tx_command = 8'hA2; tx_payload = 24'h0000A3; tx_valid = 3'b001;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_target = 8'hB1; tx_command = 8'hB2; tx_payload = 24'h00B300; tx_valid = 3'b010;
    for (int j = 0; j < 6; j++) begin
      chk("b2b_valid", {31'd0, cmd_valid}, 1);
      chk("b2b_data", {24'd0, cmd_data}, {24'd0, b2b[j]});
      chk("b2b_last", {31'd0, cmd_last}, (j == 2 || j == 5) ? 1 : 0);
      chk("b2b_txready", {31'd0, tx_ready}, (j == 2 || j == 5) ? 1 : 0);
      @(posedge clk); #1;
      if (j == 2) tx_start = 1'b0;
    end
    chk("b2b_idle", {31'd0, cmd_valid}, 0);

    // Reset during the command beat of a full message.
    send(tbl[0].t, tbl[0].c, tbl[0].p, tbl[0].v);
    @(posedge clk); #1;
    chk("pre_abort_cmd", {24'd0, cmd_data}, 32'h34);
    #2 rst = 1'b0;
    #1;
    chk("abort_valid", {31'd0, cmd_valid}, 0);
    chk("abort_ready", {31'd0, tx_ready}, 0);
    chk("abort_data",  {24'd0, cmd_data}, 0);
    @(posedge clk); #1;
    chk("abort_hold_valid", {31'd0, cmd_valid}, 0);
    rst = 1'b1;
    #1;
    chk("release_ready", {31'd0, tx_ready}, 1);
    chk("release_valid", {31'd0, cmd_valid}, 0);
    send(tbl[1].t, tbl[1].c, tbl[1].p, tbl[1].v);
    expect_beats(tbl[1]);

    // Random messages against random downstream stalls.
    fork
      begin : producer
        for (int m = 0; m < 1000; m++) begin
          logic [7:0] t, c; logic [23:0] p; logic [2:0] v;
          bit acc; int k;
          t = 8'($urandom); c = 8'($urandom); p = 24'($urandom); v = 3'($urandom);
          tx_target = t; tx_command = c; tx_payload = p; tx_valid = v; tx_start = 1'b1;
          acc = 1'b0; k = 0;
          while (!acc && k < 200) begin
            @(negedge clk);
            acc = tx_ready;
            if (acc) begin
              q.push_back({1'b0, t});
              q.push_back({(v == 3'b000), c});
              for (int i = 2; i >= 0; i--)
                if (v[i]) q.push_back({((v & 3'((1 << i) - 1)) == 3'b000), p[i*8 +: 8]});
            end
            @(posedge clk); #1;
            k++;
          end
          if (!acc) chk("accept_timeout", 0, 1);
          tx_start = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int cyc = 0;
        int stall = 0;
        bit held = 1'b0;
        logic [8:0] hb, e;
        while (!(prod_done && q.size() == 0) && cyc < 60000) begin
          @(posedge clk); #1;
          if (stall > 0) begin cmd_ready = 1'b0; stall--; end
          else begin
            cmd_ready = 1'b1;
            stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
          end
          @(negedge clk);
          cyc++;
          if (held) chk("stall_hold", {22'd0, cmd_valid, cmd_last, cmd_data}, {22'd0, 1'b1, hb});
          if (cmd_valid && !cmd_ready) begin held = 1'b1; hb = {cmd_last, cmd_data}; end
          else held = 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (q.size() == 0) chk("stream_extra_beat", 1, 0);
            else begin
              e = q.pop_front();
              chk("stream_beat", {23'd0, cmd_last, cmd_data}, {23'd0, e});
            end
          end
        end
        if (cyc >= 60000) chk("stream_timeout", 0, 1);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nx_transmitter.md
NX_TRANSMITTER -- requirements
Module: nx_transmitter

Interface
REQ-001 SHALL have parameter TARGET_W, default 8: width of the target field, 1..BUS_W.
REQ-002 SHALL have parameter BUS_W, default 8: width of one command-bus beat.
REQ-003 SHALL have parameter PAYLOAD_W, default 24: payload width, an integer multiple of BUS_W; N = PAYLOAD_W/BUS_W payload beats maximum.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous assert, active-low
- tx_target  in  TARGET_W  destination of the message
- tx_command  in  BUS_W  command byte
- tx_payload  in  PAYLOAD_W  payload; beat i = tx_payload[i*BUS_W +: BUS_W]
- tx_valid  in  N  per-beat payload-present mask
- tx_start  in  1  message offered
- tx_ready  out  1  message accepted when tx_start && tx_ready
- cmd_data  out  BUS_W  serial command bus data
- cmd_last  out  1  final beat of the message
- cmd_valid  out  1  beat valid
- cmd_ready  in  1  downstream accepts the beat when cmd_valid && cmd_ready

Function
REQ-005 SHALL capture tx_target, tx_command, tx_payload and tx_valid into internal registers on each accepted message; later changes to tx_* SHALL NOT affect the message in flight.
REQ-006 SHALL implement states IDLE, TARGET, COMMAND, PAYLOAD.
REQ-007 IDLE: cmd_valid=0, tx_ready=1; on acceptance -> TARGET.
REQ-008 TARGET: cmd_data = zero-extended target, cmd_last=0; on beat handshake -> COMMAND.
REQ-009 COMMAND: cmd_data = command; cmd_last=1 iff the captured mask is 0; on handshake -> PAYLOAD if the mask is nonzero, else end of message.
REQ-010 PAYLOAD: SHALL emit one beat per set mask bit, highest index first, cmd_data = that payload slice, clearing the bit once the beat is accepted; cmd_last=1 on the beat for the lowest set bit; unset beats SHALL be skipped with no idle cycle.
REQ-011 On end of message (last-beat handshake): -> TARGET if a new message is accepted in the same cycle, else -> IDLE.
REQ-012 tx_ready SHALL be 1 in IDLE, and also in any cycle where cmd_valid && cmd_ready && cmd_last; 0 otherwise. This is a combinational path from cmd_ready.
REQ-013 With cmd_ready held high, a message with k set mask bits SHALL occupy exactly 2+k consecutive cycles; back-to-back messages SHALL have zero idle cycles between them.
REQ-014 Latency: the first beat (target) SHALL appear with cmd_valid=1 in the cycle after acceptance.
REQ-015 While cmd_valid && !cmd_ready: cmd_data, cmd_last and cmd_valid SHALL hold stable; cmd_valid SHALL NOT deassert before its handshake.
REQ-016 cmd_valid SHALL be 1 in TARGET, COMMAND and PAYLOAD states.
REQ-017 tx_start while tx_ready=0 SHALL be ignored; the offerer holds it.

Reset
REQ-018 While rst=0: state=IDLE, cmd_valid=0, cmd_last=0, cmd_data=0, tx_ready=0, capture registers=0.
REQ-019 Reset asserted mid-message SHALL abort it immediately with no further beats; after release the block SHALL be in IDLE with tx_ready=1 in the first cycle.

Verification
REQ-020 T=0x12, C=0x34, P=0xAABBCC, V=111, cmd_ready=1 -> beats 12,34,AA,BB,CC over 5 cycles; last on CC.
REQ-021 T=0x01, C=0x80, P=0x112233, V=101 -> beats 01,80,11,33; last on 33; byte 22 never sent.
REQ-022 V=000, T=0x05, C=0x06 -> beats 05,06 with last on 06; then IDLE.
REQ-023 Two messages offered back-to-back (V=001 then V=010), cmd_ready=1 -> 6 consecutive valid beats, no gap; tx_ready=1 on both last beats.
REQ-024 Random cmd_ready stalls of 0..4 cycles over 1000 random messages -> stalled beats stable; the serial stream, parsed by a reference model, matches every offered message in order.
REQ-025 rst driven low during the COMMAND beat of V=111 -> cmd_valid=0 asynchronously; after release, the next message is sent intact from its target beat.
